// File: rtl/axi_write_channel_stats.sv
// Passive AXI4 write-path observer: per-channel handshake/stall counters, outstanding-write
// tracking and sticky protocol-error flags checking W burst length against AWLEN.
module axi_write_channel_stats #(
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned LEN_FIFO_DEPTH = 4,
  parameter int unsigned OUTST_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   axi_aw_valid,
  input  logic                   axi_aw_ready,
  input  logic [7:0]             axi_aw_len,
  input  logic [ID_WIDTH-1:0]    axi_aw_id,
  input  logic                   axi_w_valid,
  input  logic                   axi_w_ready,
  input  logic                   axi_w_last,
  input  logic                   axi_b_valid,
  input  logic                   axi_b_ready,
  input  logic [1:0]             axi_b_resp,
  output logic [CNT_WIDTH-1:0]   aw_xfer_cnt,
  output logic [CNT_WIDTH-1:0]   w_xfer_cnt,
  output logic [CNT_WIDTH-1:0]   b_xfer_cnt,
  output logic [CNT_WIDTH-1:0]   aw_stall_cnt,
  output logic [CNT_WIDTH-1:0]   w_stall_cnt,
  output logic [CNT_WIDTH-1:0]   b_stall_cnt,
  output logic [CNT_WIDTH-1:0]   b_err_cnt,
  output logic [OUTST_WIDTH-1:0] outstanding,
  output logic                   err_wlast_early,
  output logic                   err_wlast_missing,
  output logic                   err_w_no_aw,
  output logic                   err_len_ovf,
  output logic                   err_b_unexpected,
  output logic                   err_any
);

  localparam int unsigned PtrW = $clog2(LEN_FIFO_DEPTH);
  localparam int unsigned QCntW = PtrW + 1;

  logic unused_id;
  assign unused_id = ^axi_aw_id;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    return (inc && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  logic [7:0]             len_mem_q [LEN_FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [QCntW-1:0]       q_cnt_q, q_cnt_d;
  logic [7:0]             beat_q, beat_d;
  logic [OUTST_WIDTH-1:0] outst_q, outst_d;
  logic [CNT_WIDTH-1:0]   aw_xfer_q, w_xfer_q, b_xfer_q, aw_stall_q, w_stall_q, b_stall_q;
  logic [CNT_WIDTH-1:0]   b_err_q;
  logic                   early_q, missing_q, no_aw_q, ovf_q, b_unexp_q, any_q;
  logic                   early_d, missing_d, no_aw_d, ovf_d, b_unexp_d, any_d;

  logic       hs_aw, hs_w, hs_b, q_empty, q_full, have_len, burst_end, push, pop;
  logic [7:0] head_len;

  always_comb begin
    hs_aw   = axi_aw_valid && axi_aw_ready;
    hs_w    = axi_w_valid && axi_w_ready;
    hs_b    = axi_b_valid && axi_b_ready;
    q_empty = (q_cnt_q == '0);
    q_full  = (q_cnt_q == QCntW'(LEN_FIFO_DEPTH));
    // An AW accepted in the same cycle as a W beat on an empty queue supplies its length.
    head_len  = q_empty ? axi_aw_len : len_mem_q[rd_ptr_q];
    have_len  = hs_w && (!q_empty || hs_aw);
    burst_end = have_len && (axi_w_last || (beat_q == head_len));
    pop       = burst_end;
    push      = hs_aw && (!q_full || pop);
    q_cnt_d   = q_cnt_q + QCntW'(push) - QCntW'(pop);

    if (burst_end)     beat_d = '0;
    else if (have_len) beat_d = beat_q + 8'd1;
    else               beat_d = beat_q;

    early_d   = early_q   || (have_len && axi_w_last && (beat_q < head_len));
    missing_d = missing_q || (have_len && !axi_w_last && (beat_q == head_len));
    no_aw_d   = no_aw_q   || (hs_w && q_empty && !hs_aw);
    ovf_d     = ovf_q     || (hs_aw && q_full && !pop);
    b_unexp_d = b_unexp_q || (hs_b && !hs_aw && (outst_q == '0));
    any_d     = early_d || missing_d || no_aw_d || ovf_d || b_unexp_d;

    outst_d = outst_q;
    if (hs_aw && !hs_b && (outst_q != '1)) outst_d = outst_q + OUTST_WIDTH'(1);
    else if (hs_b && !hs_aw && (outst_q != '0)) outst_d = outst_q - OUTST_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LEN_FIFO_DEPTH; i++) len_mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      q_cnt_q    <= '0;
      beat_q     <= '0;
      outst_q    <= '0;
      aw_xfer_q  <= '0;
      w_xfer_q   <= '0;
      b_xfer_q   <= '0;
      aw_stall_q <= '0;
      w_stall_q  <= '0;
      b_stall_q  <= '0;
      b_err_q    <= '0;
      early_q    <= 1'b0;
      missing_q  <= 1'b0;
      no_aw_q    <= 1'b0;
      ovf_q      <= 1'b0;
      b_unexp_q  <= 1'b0;
      any_q      <= 1'b0;
    end else if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      q_cnt_q    <= '0;
      beat_q     <= '0;
      outst_q    <= '0;
      aw_xfer_q  <= '0;
      w_xfer_q   <= '0;
      b_xfer_q   <= '0;
      aw_stall_q <= '0;
      w_stall_q  <= '0;
      b_stall_q  <= '0;
      b_err_q    <= '0;
      early_q    <= 1'b0;
      missing_q  <= 1'b0;
      no_aw_q    <= 1'b0;
      ovf_q      <= 1'b0;
      b_unexp_q  <= 1'b0;
      any_q      <= 1'b0;
    end else begin
      if (push) begin
        len_mem_q[wr_ptr_q] <= axi_aw_len;
        wr_ptr_q            <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      q_cnt_q    <= q_cnt_d;
      beat_q     <= beat_d;
      outst_q    <= outst_d;
      aw_xfer_q  <= sat_inc(aw_xfer_q, en && hs_aw);
      w_xfer_q   <= sat_inc(w_xfer_q, en && hs_w);
      b_xfer_q   <= sat_inc(b_xfer_q, en && hs_b);
      aw_stall_q <= sat_inc(aw_stall_q, en && axi_aw_valid && !axi_aw_ready);
      w_stall_q  <= sat_inc(w_stall_q, en && axi_w_valid && !axi_w_ready);
      b_stall_q  <= sat_inc(b_stall_q, en && axi_b_valid && !axi_b_ready);
      b_err_q    <= sat_inc(b_err_q, en && hs_b && (axi_b_resp != 2'b00));
      early_q    <= early_d;
      missing_q  <= missing_d;
      no_aw_q    <= no_aw_d;
      ovf_q      <= ovf_d;
      b_unexp_q  <= b_unexp_d;
      any_q      <= any_d;
    end
  end

  assign aw_xfer_cnt       = aw_xfer_q;
  assign w_xfer_cnt        = w_xfer_q;
  assign b_xfer_cnt        = b_xfer_q;
  assign aw_stall_cnt      = aw_stall_q;
  assign w_stall_cnt       = w_stall_q;
  assign b_stall_cnt       = b_stall_q;
  assign b_err_cnt         = b_err_q;
  assign outstanding       = outst_q;
  assign err_wlast_early   = early_q;
  assign err_wlast_missing = missing_q;
  assign err_w_no_aw       = no_aw_q;
  assign err_len_ovf       = ovf_q;
  assign err_b_unexpected  = b_unexp_q;
  assign err_any           = any_q;

endmodule

// File: tb/tb_axi_write_channel_stats.sv
// Directed bench for axi_write_channel_stats: expectations are queued as stimulus is driven
// and popped against DUT outputs one cycle later.
module tb_axi_write_channel_stats;

  logic       clk = 1'b0;
  logic       rst_n, clr, en;
  logic       aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [7:0] aw_len;
  logic [3:0] aw_id;
  logic [1:0] b_resp;

  logic [31:0] aw_xfer, w_xfer, b_xfer, aw_stall, w_stall, b_stall, b_err;
  logic [7:0]  outst;
  logic        e_early, e_missing, e_no_aw, e_ovf, e_bun, e_any;

  logic [3:0] s_aw_xfer, s_w_xfer, s_b_xfer, s_aw_stall, s_w_stall, s_b_stall, s_b_err;
  logic [7:0] s_outst;
  logic       s_early, s_missing, s_no_aw, s_ovf, s_bun, s_any;

  always #5 clk = ~clk;

  axi_write_channel_stats dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en),
    .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready), .axi_aw_len(aw_len), .axi_aw_id(aw_id),
    .axi_w_valid(w_valid), .axi_w_ready(w_ready), .axi_w_last(w_last),
    .axi_b_valid(b_valid), .axi_b_ready(b_ready), .axi_b_resp(b_resp),
    .aw_xfer_cnt(aw_xfer), .w_xfer_cnt(w_xfer), .b_xfer_cnt(b_xfer),
    .aw_stall_cnt(aw_stall), .w_stall_cnt(w_stall), .b_stall_cnt(b_stall),
    .b_err_cnt(b_err), .outstanding(outst),
    .err_wlast_early(e_early), .err_wlast_missing(e_missing), .err_w_no_aw(e_no_aw),
    .err_len_ovf(e_ovf), .err_b_unexpected(e_bun), .err_any(e_any)
  );

  axi_write_channel_stats #(.CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en),
    .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready), .axi_aw_len(aw_len), .axi_aw_id(aw_id),
    .axi_w_valid(w_valid), .axi_w_ready(w_ready), .axi_w_last(w_last),
    .axi_b_valid(b_valid), .axi_b_ready(b_ready), .axi_b_resp(b_resp),
    .aw_xfer_cnt(s_aw_xfer), .w_xfer_cnt(s_w_xfer), .b_xfer_cnt(s_b_xfer),
    .aw_stall_cnt(s_aw_stall), .w_stall_cnt(s_w_stall), .b_stall_cnt(s_b_stall),
    .b_err_cnt(s_b_err), .outstanding(s_outst),
    .err_wlast_early(s_early), .err_wlast_missing(s_missing), .err_w_no_aw(s_no_aw),
    .err_len_ovf(s_ovf), .err_b_unexpected(s_bun), .err_any(s_any)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_v(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d required=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0d required=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0; b_valid = 1'b0;
    aw_ready = 1'b1; w_ready = 1'b1; b_ready = 1'b1; b_resp = 2'b00;
  endtask

  task automatic do_clr();
    idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    idle();
    en = 1'b1; aw_len = 8'd0; aw_id = 4'h5; rst_n = 1'b0;
    #12;
    expect_v("rst_aw_xfer", 0); expect_v("rst_outst", 0); expect_v("rst_err_any", 0);
    expect_v("rst_w_stall", 0);
    chk(aw_xfer); chk(32'(outst)); chk(32'(e_any)); chk(w_stall);
    rst_n = 1'b1;
    tick();

    // Legal burst of 4 beats then OKAY response
    aw_valid = 1'b1; aw_len = 8'd3;
    expect_v("t1_aw_xfer", 1); expect_v("t1_outst_up", 1);
    tick(); aw_valid = 1'b0;
    chk(aw_xfer); chk(32'(outst));
    w_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_last = (i == 3);
      tick();
    end
    w_valid = 1'b0; w_last = 1'b0;
    expect_v("t1_w_xfer", 4); expect_v("t1_err_any", 0);
    chk(w_xfer); chk(32'(e_any));
    b_valid = 1'b1; b_resp = 2'b00;
    expect_v("t1_b_xfer", 1); expect_v("t1_outst_down", 0); expect_v("t1_b_err", 0);
    tick(); b_valid = 1'b0;
    chk(b_xfer); chk(32'(outst)); chk(b_err);

    // AW stall then early WLAST
    do_clr();
    aw_valid = 1'b1; aw_ready = 1'b0; aw_len = 8'd3;
    tick(); tick();
    aw_ready = 1'b1;
    tick(); aw_valid = 1'b0;
    expect_v("t2_aw_stall", 2); expect_v("t2_aw_xfer", 1);
    chk(aw_stall); chk(aw_xfer);
    w_valid = 1'b1; w_last = 1'b0; tick();
    w_last = 1'b1; tick();
    w_valid = 1'b0; w_last = 1'b0;
    expect_v("t2_early", 1); expect_v("t2_missing", 0); expect_v("t2_no_aw_before", 0);
    chk(32'(e_early)); chk(32'(e_missing)); chk(32'(e_no_aw));
    w_valid = 1'b1; w_last = 1'b1;
    expect_v("t2_queue_empty", 1);
    tick(); idle();
    chk(32'(e_no_aw));

    // Missing WLAST
    do_clr();
    aw_valid = 1'b1; aw_len = 8'd1; tick(); aw_valid = 1'b0;
    w_valid = 1'b1; w_last = 1'b0; tick(); tick(); idle();
    expect_v("t2b_missing", 1); expect_v("t2b_early", 0); expect_v("t2b_any", 1);
    chk(32'(e_missing)); chk(32'(e_early)); chk(32'(e_any));

    // Queue overflow, then one orphan W beat
    do_clr();
    aw_valid = 1'b1; aw_len = 8'd0;
    for (int i = 0; i < 5; i++) tick();
    aw_valid = 1'b0;
    expect_v("t3_ovf", 1); expect_v("t3_outst", 5); expect_v("t3_aw_xfer", 5);
    chk(32'(e_ovf)); chk(32'(outst)); chk(aw_xfer);
    w_valid = 1'b1; w_last = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    expect_v("t3_no_aw_4", 0);
    chk(32'(e_no_aw));
    expect_v("t3_no_aw_5", 1); expect_v("t3_w_xfer", 5);
    tick(); idle();
    chk(32'(e_no_aw)); chk(w_xfer);

    // Full queue with same-cycle push and pop
    do_clr();
    aw_valid = 1'b1; aw_len = 8'd0;
    for (int i = 0; i < 4; i++) tick();
    w_valid = 1'b1; w_last = 1'b1;
    expect_v("t3b_ovf", 0); expect_v("t3b_outst", 5);
    tick(); aw_valid = 1'b0;
    chk(32'(e_ovf)); chk(32'(outst));
    for (int i = 0; i < 4; i++) tick();
    idle();
    expect_v("t3b_no_aw", 0); expect_v("t3b_w_xfer", 5);
    chk(32'(e_no_aw)); chk(w_xfer);

    // Unexpected B with SLVERR
    do_clr();
    b_valid = 1'b1; b_resp = 2'b10;
    expect_v("t4_b_unexp", 1); expect_v("t4_b_err", 1); expect_v("t4_outst", 0);
    expect_v("t4_b_xfer", 1);
    tick(); idle();
    chk(32'(e_bun)); chk(b_err); chk(32'(outst)); chk(b_xfer);

    // Same-cycle AW and W on an empty queue, then clr
    do_clr();
    aw_valid = 1'b1; aw_len = 8'd0; w_valid = 1'b1; w_last = 1'b1;
    expect_v("t5_no_aw", 0); expect_v("t5_outst", 1); expect_v("t5_w_xfer", 1);
    expect_v("t5_any", 0);
    tick(); aw_valid = 1'b0;
    chk(32'(e_no_aw)); chk(32'(outst)); chk(w_xfer); chk(32'(e_any));
    expect_v("t5_queue_empty", 1);
    tick(); idle();
    chk(32'(e_no_aw));
    clr = 1'b1; aw_valid = 1'b1; w_valid = 1'b1; w_last = 1'b1;
    expect_v("t5_clr_aw", 0); expect_v("t5_clr_w", 0); expect_v("t5_clr_outst", 0);
    expect_v("t5_clr_any", 0); expect_v("t5_clr_no_aw", 0);
    tick(); idle();
    chk(aw_xfer); chk(w_xfer); chk(32'(outst)); chk(32'(e_any)); chk(32'(e_no_aw));

    // Stall counter saturation on the narrow-counter instance
    do_clr();
    w_valid = 1'b1; w_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    idle();
    expect_v("t6_s_w_stall", 15); expect_v("t6_w_stall", 20);
    chk(32'(s_w_stall)); chk(w_stall);

    // Counting disabled: outstanding still tracks
    do_clr();
    en = 1'b0; aw_valid = 1'b1; aw_len = 8'd0;
    expect_v("t7_aw_xfer", 0); expect_v("t7_outst", 1);
    tick(); idle(); en = 1'b1;
    chk(aw_xfer); chk(32'(outst));

    // Reset mid-burst discards queue and beat state
    do_clr();
    aw_valid = 1'b1; aw_len = 8'd3; tick(); aw_valid = 1'b0;
    w_valid = 1'b1; w_last = 1'b0; tick(); idle();
    rst_n = 1'b0;
    #2;
    expect_v("t8_rst_outst", 0); expect_v("t8_rst_w_xfer", 0);
    chk(32'(outst)); chk(w_xfer);
    rst_n = 1'b1;
    aw_valid = 1'b1; aw_len = 8'd0; w_valid = 1'b1; w_last = 1'b1;
    expect_v("t8_any", 0); expect_v("t8_outst", 1);
    tick(); idle();
    chk(32'(e_any)); chk(32'(outst));
    tick();
    expect_v("t8_quiet", 0);
    chk(32'(e_any));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
